// File: rtl/common.sv
// Shared instruction-bus types and helpers used by the fetch stage and the
// memory-side responder.
package common;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam addr_t PCINIT               = 32'h8000_0000;
  localparam int    IBUS_DEFAULT_LATENCY = 2;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ibus_state_e;

  // Range is checked before subtracting so the offset never wraps below base.
  function automatic logic ibus_addr_bad(input addr_t addr, input addr_t base,
                                         input addr_t words);
    logic  bad;
    addr_t off;
    bad = (addr[1:0] != 2'b00);
    off = '0;
    if (addr < base) begin
      bad = 1'b1;
    end else begin
      off = (addr - base) >> 2'd2;
      if (off >= words) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/ibus_mem_array.sv
// Instruction word store: synchronous read register (read-before-write) and
// an independent synchronous write port for backdoor loading.
module ibus_mem_array
  import common::*;
#(
  parameter int    WORDS     = 4096,
  parameter int    IDX_W     = $clog2(WORDS),
  parameter string INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output word_t            rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  word_t            wr_data_i
);

  word_t mem_q [WORDS];
  word_t rd_data_q;

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read register holds zero except in the cycle after a read strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ibus_responder.sv
// Memory end of the instruction bus: one held-valid request at a time,
// configurable wait latency, one-cycle addr_ok/data_ok response.
module ibus_responder
  import common::*;
#(
  parameter int    MEM_WORDS = 4096,
  parameter addr_t BASE_ADDR = PCINIT,
  parameter int    LATENCY   = IBUS_DEFAULT_LATENCY,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  ibus_req_t                    ireq,
  output ibus_resp_t                   iresp,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [31:0]                  load_data,
  output logic                         fault,
  output logic                         busy
);

  localparam int                IDX_W    = $clog2(MEM_WORDS);
  localparam int                CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam addr_t             WORDS_A  = addr_t'(MEM_WORDS);

  ibus_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  addr_t            req_addr_q;
  logic             ok_q;
  logic             fault_q;
  logic             busy_q;

  addr_t            sel_addr_s;
  logic             enter_resp_s;
  logic             bad_s;
  logic             rd_en_s;
  logic [IDX_W-1:0] rd_idx_s;
  word_t            rd_data_s;

  // Decide whether this edge enters RESP and decode the address it will serve.
  always_comb begin
    sel_addr_s   = req_addr_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ireq.valid && (LATENCY == 0)) begin
          sel_addr_s   = ireq.addr;
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (ireq.valid && (ireq.addr == req_addr_q) && (cnt_q == CNT_ONE)) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      default: enter_resp_s = 1'b0;
    endcase
    bad_s    = ibus_addr_bad(sel_addr_s, BASE_ADDR, WORDS_A);
    rd_en_s  = enter_resp_s && !bad_s;
    rd_idx_s = IDX_W'((sel_addr_s - BASE_ADDR) >> 2'd2);
  end

  // Request FSM with registered handshake, fault and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      ok_q       <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ok_q    <= 1'b0;
          fault_q <= 1'b0;
          if (ireq.valid) begin
            req_addr_q <= ireq.addr;
            busy_q     <= 1'b1;
            if (enter_resp_s) begin
              state_q <= ST_RESP;
              ok_q    <= 1'b1;
              fault_q <= bad_s;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!ireq.valid) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (ireq.addr != req_addr_q) begin
            req_addr_q <= ireq.addr;
            cnt_q      <= CNT_LOAD;
          end else if (enter_resp_s) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
            ok_q    <= 1'b1;
            fault_q <= bad_s;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ok_q    <= 1'b0;
          fault_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          ok_q    <= 1'b0;
          fault_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ibus_mem_array #(
    .WORDS    (MEM_WORDS),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk_i    (clk),
    .rst_ni   (rst),
    .rd_en_i  (rd_en_s),
    .rd_idx_i (rd_idx_s),
    .rd_data_o(rd_data_s),
    .wr_en_i  (load_en),
    .wr_idx_i (load_idx),
    .wr_data_i(load_data)
  );

  assign iresp.addr_ok = ok_q;
  assign iresp.data_ok = ok_q;
  assign iresp.data    = rd_data_s;
  assign fault         = fault_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder: one LATENCY=2 and one LATENCY=0 instance.
module tb_ibus_responder;
  import common::*;

  localparam addr_t BASE = PCINIT;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  req_a, req_b;
  ibus_resp_t resp_a, resp_b;
  logic       load_en;
  logic [11:0] load_idx;
  logic [31:0] load_data;
  logic       fault_a, busy_a, fault_b, busy_b;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ibus_responder #(.MEM_WORDS(4096), .BASE_ADDR(BASE), .LATENCY(2), .INIT_FILE("")) u_dut_l2 (
    .clk(clk), .rst(rst), .ireq(req_a), .iresp(resp_a), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .fault(fault_a), .busy(busy_a)
  );

  ibus_responder #(.MEM_WORDS(4096), .BASE_ADDR(BASE), .LATENCY(0), .INIT_FILE("")) u_dut_l0 (
    .clk(clk), .rst(rst), .ireq(req_b), .iresp(resp_b), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .fault(fault_b), .busy(busy_b)
  );

  function automatic logic [3:0] ctl_a();
    return {resp_a.addr_ok, resp_a.data_ok, fault_a, busy_a};
  endfunction

  function automatic logic [3:0] ctl_b();
    return {resp_b.addr_ok, resp_b.data_ok, fault_b, busy_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed ok/ok/fault/busy=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  // Full LATENCY=2 transaction: request in cycle 0, response in cycle 3, idle in 4.
  task automatic txn_a(input string tag, input addr_t addr, input logic [31:0] exp_data,
                       input logic exp_fault);
    req_a.valid = 1'b1;
    req_a.addr  = addr;
    tick();
    chk_ctl({tag, " c1"}, ctl_a(), 4'b0001);
    tick();
    chk_ctl({tag, " c2"}, ctl_a(), 4'b0001);
    tick();
    chk_ctl({tag, " c3 ctl"}, ctl_a(), {1'b1, 1'b1, exp_fault, 1'b1});
    chk({tag, " c3 data"}, resp_a.data, exp_data);
    req_a.valid = 1'b0;
    tick();
    chk_ctl({tag, " c4"}, ctl_a(), 4'b0000);
  endtask

  initial begin
    rst       = 1'b0;
    req_a     = '0;
    req_b     = '0;
    load_en   = 1'b0;
    load_idx  = 12'd0;
    load_data = 32'd0;
    tick();
    tick();
    chk_ctl("reset ctl a", ctl_a(), 4'b0000);
    chk("reset data a", resp_a.data, 32'h0000_0000);
    chk_ctl("reset ctl b", ctl_b(), 4'b0000);
    rst = 1'b1;
    tick();

    load(12'd0, 32'h0000_0093);
    load(12'd1, 32'h1111_1111);
    load(12'd2, 32'h2222_2222);
    load(12'd3, 32'h3333_3333);

    // Basic fetch of word 0.
    txn_a("t1 base", BASE, 32'h0000_0093, 1'b0);

    // LATENCY=0: two requests separated by a one-cycle valid gap.
    req_b.valid = 1'b1;
    req_b.addr  = BASE + 32'd4;
    tick();
    chk_ctl("l0 r1 c1 ctl", ctl_b(), 4'b1101);
    chk("l0 r1 c1 data", resp_b.data, 32'h1111_1111);
    tick();
    chk_ctl("l0 c2 idle", ctl_b(), 4'b0000);
    req_b.valid = 1'b0;
    tick();
    chk_ctl("l0 c3 idle", ctl_b(), 4'b0000);
    req_b.valid = 1'b1;
    req_b.addr  = BASE + 32'd8;
    tick();
    chk_ctl("l0 r2 c4 ctl", ctl_b(), 4'b1101);
    chk("l0 r2 c4 data", resp_b.data, 32'h2222_2222);
    req_b.valid = 1'b0;
    tick();
    chk_ctl("l0 c5 idle", ctl_b(), 4'b0000);

    // Abandoned request during the first WAIT cycle.
    req_a.valid = 1'b1;
    req_a.addr  = BASE + 32'd4;
    tick();
    chk_ctl("abandon c1", ctl_a(), 4'b0001);
    req_a.valid = 1'b0;
    tick();
    chk_ctl("abandon c2", ctl_a(), 4'b0000);
    tick();
    chk_ctl("abandon c3", ctl_a(), 4'b0000);
    txn_a("t3 next", BASE + 32'd8, 32'h2222_2222, 1'b0);

    // Address change mid-WAIT restarts the latency.
    req_a.valid = 1'b1;
    req_a.addr  = BASE;
    tick();
    req_a.addr = BASE + 32'd12;
    tick();
    chk_ctl("chg c2", ctl_a(), 4'b0001);
    tick();
    chk_ctl("chg c3", ctl_a(), 4'b0001);
    tick();
    chk_ctl("chg c4 ctl", ctl_a(), 4'b1101);
    chk("chg c4 data", resp_a.data, 32'h3333_3333);
    req_a.valid = 1'b0;
    tick();
    chk_ctl("chg c5", ctl_a(), 4'b0000);

    // Bad addresses: misaligned, one past the end, below base.
    txn_a("t5 misaligned", BASE + 32'd2, 32'h0000_0000, 1'b1);
    txn_a("t5 past end", BASE + 32'h0000_4000, 32'h0000_0000, 1'b1);
    txn_a("t5 below base", BASE - 32'd4, 32'h0000_0000, 1'b1);

    // Backdoor write colliding with the response read returns the old word.
    req_a.valid = 1'b1;
    req_a.addr  = BASE + 32'd4;
    tick();
    tick();
    load_en   = 1'b1;
    load_idx  = 12'd1;
    load_data = 32'hAAAA_AAAA;
    tick();
    load_en = 1'b0;
    chk_ctl("coll c3 ctl", ctl_a(), 4'b1101);
    chk("coll old word", resp_a.data, 32'h1111_1111);
    req_a.valid = 1'b0;
    tick();
    txn_a("coll new word", BASE + 32'd4, 32'hAAAA_AAAA, 1'b0);

    // Reset asserted in RESP clears outputs in the same cycle.
    req_a.valid = 1'b1;
    req_a.addr  = BASE;
    tick();
    tick();
    tick();
    chk_ctl("rst pre ctl", ctl_a(), 4'b1101);
    rst = 1'b0;
    #1;
    chk_ctl("rst async ctl", ctl_a(), 4'b0000);
    chk("rst async data", resp_a.data, 32'h0000_0000);
    req_a.valid = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    txn_a("post rst mem0", BASE, 32'h0000_0093, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
